if_stage: RTL

Instruction-fetch stage of the 5-stage RV64I pipeline. Owns the fetch PC and drives a single-outstanding-request handshake to instruction memory. Registers each returned instruction, with its PC and PC+4, into the IF/ID slot consumed by decode, which in turn feeds the ID/EX register. Honors load-use stalls from the hazard unit and taken-branch/JAL/JALR redirects from EX; stale responses are discarded.

---
 rtl/if_stage.sv | 90 +++++++++
 1 files changed

// File: rtl/if_stage.sv
// if_stage: RV64I instruction fetch with a single-outstanding imem handshake, IF/ID slot and one-entry skid buffer.
module if_stage #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        imem_req_valid,
    output logic [63:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        if_id_valid,
    output logic [63:0] if_id_pc,
    output logic [63:0] if_id_pc_plus4,
    output logic [31:0] if_id_instr,
    output logic        misaligned_redirect
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_t;
    state_t state, state_nxt;
    logic [63:0] fetch_pc, skid_pc, load_pc;
    logic [31:0] skid_instr, load_instr;
    logic skid_valid, accept, deliver, load_slot;

    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else state <= state_nxt;

    // A redirect that catches a request already in flight must drain its response.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = REQ;
            REQ:     state_nxt = accept ? (redirect_valid ? DRAIN : WAIT) : REQ;
            WAIT:    state_nxt = imem_resp_valid ? REQ : (redirect_valid ? DRAIN : WAIT);
            DRAIN:   state_nxt = imem_resp_valid ? REQ : DRAIN;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        imem_req_valid = state == REQ && !skid_valid;
        imem_req_addr = fetch_pc;
        accept = imem_req_valid && imem_req_ready;
        deliver = state == WAIT && imem_resp_valid;
    end

    // Skid and delivery never coincide: no request issues while the skid is full.
    always_comb begin
        load_slot = stall ? deliver && !if_id_valid : skid_valid || deliver;
        load_pc = skid_valid ? skid_pc : fetch_pc;
        load_instr = skid_valid ? skid_instr : imem_resp_data;
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            fetch_pc <= RESET_PC;
            if_id_valid <= 1'b0;
            if_id_pc <= 64'h0;
            if_id_pc_plus4 <= 64'h4;
            if_id_instr <= 32'h0000_0013;
            skid_valid <= 1'b0;
            skid_pc <= 64'h0;
            skid_instr <= 32'h0000_0013;
            misaligned_redirect <= 1'b0;
        end else begin
            misaligned_redirect <= redirect_valid && |redirect_pc[1:0];
            if (redirect_valid) begin
                fetch_pc <= {redirect_pc[63:2], 2'b00};
                if_id_valid <= 1'b0;
                skid_valid <= 1'b0;
            end else begin
                if (deliver) fetch_pc <= fetch_pc + 64'd4;
                if (!stall || load_slot) if_id_valid <= load_slot;
                if (load_slot) begin
                    if_id_pc <= load_pc;
                    if_id_pc_plus4 <= load_pc + 64'd4;
                    if_id_instr <= load_instr;
                end
                if (!stall) skid_valid <= 1'b0;
                else if (deliver && if_id_valid) begin
                    skid_valid <= 1'b1;
                    skid_pc <= fetch_pc;
                    skid_instr <= imem_resp_data;
                end
            end
        end
endmodule
